// File: rtl/sprite_sched_pkg.sv
// Shared definitions for the sprite command scheduler: display bus word layout,
// control codes, scheduler states and small word helpers.
package sprite_sched_pkg;

  localparam int CID_MSB   = 31;
  localparam int CID_LSB   = 26;
  localparam int CHILD_MSB = 25;
  localparam int CHILD_LSB = 21;
  localparam int CC_MSB    = 20;
  localparam int CC_LSB    = 17;
  localparam int DTYPE_MSB = 16;
  localparam int DTYPE_LSB = 14;
  localparam int BUF_BIT   = 13;
  localparam int DATA_MSB  = 12;
  localparam int DATA_LSB  = 0;

  localparam logic [3:0]  CC_NOP    = 4'h0;
  localparam logic [3:0]  CC_UPDATE = 4'h1;
  localparam logic [3:0]  CC_SWAP   = 4'hF;
  localparam logic [31:0] IDLE_WORD = 32'h0;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_WAIT_VBLANK = 2'd1,
    ST_SWAP        = 2'd2
  } sched_state_e;

  function automatic logic [3:0] ctrl_code(input logic [31:0] word);
    return word[CC_MSB:CC_LSB];
  endfunction

  function automatic logic [31:0] swap_word(input logic bsel);
    logic [31:0] word;
    word                = IDLE_WORD;
    word[CC_MSB:CC_LSB] = CC_SWAP;
    word[BUF_BIT]       = bsel;
    return word;
  endfunction

endpackage

// File: rtl/sprite_cmd_scheduler_if.sv
// Host-side command/status signals and the broadcast display bus of the scheduler.
interface sprite_cmd_scheduler_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          host_write;
  logic [31:0]                   host_writedata;
  logic                          host_commit;
  logic [9:0]                    hcount;
  logic [9:0]                    vcount;
  logic [31:0]                   disp_writedata;
  logic                          active_buffer;
  logic                          host_ready;
  logic                          commit_pending;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [7:0]                    frame_count;
  logic [1:0]                    err_flags;

  modport master (
    output host_write, host_writedata, host_commit, hcount, vcount,
    input  disp_writedata, active_buffer, host_ready, commit_pending,
           fifo_count, frame_count, err_flags
  );

  modport slave (
    input  host_write, host_writedata, host_commit, hcount, vcount,
    output disp_writedata, active_buffer, host_ready, commit_pending,
           fifo_count, frame_count, err_flags
  );
endinterface

// File: rtl/sched_cmd_fifo.sv
// Synchronous command FIFO with registered read data and occupancy count.
// A write on a full FIFO is accepted when a read happens in the same cycle.
module sched_cmd_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  // storage and read register carry no reset; validity is tracked by the caller
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
    if (rd_ok) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sprite_cmd_scheduler.sv
// Drains host sprite commands onto the display bus and issues a buffer swap
// word at the vertical blanking line once a commit has fully drained.
module sprite_cmd_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [9:0] VBLANK_LINE = 10'd480
) (
  input  logic                     clk,
  input  logic                     reset,
  sprite_cmd_scheduler_if.slave    bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e state;
  logic [31:0]  fifo_rd_data;
  logic [CW-1:0] fifo_cnt;
  logic         fifo_full;
  logic         fifo_empty;
  logic         illegal_p0;
  logic         push_p0;
  logic         pop_p0;
  logic         vld_p1;
  logic         vblank_hit;
  logic         active_buffer;
  logic         commit_pending;
  logic [7:0]   frame_count;
  logic [1:0]   err_flags;
  logic [31:0]  disp_word;

  // host-side intake: swap words from the host are never queued
  assign illegal_p0 = bus.host_write && (ctrl_code(bus.host_writedata) == CC_SWAP);
  assign push_p0    = bus.host_write && !illegal_p0;
  assign pop_p0     = (state == ST_RUN) && !fifo_empty;
  assign vblank_hit = (bus.vcount == VBLANK_LINE) && (bus.hcount == 10'd0);

  sched_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (push_p0),
    .wr_data (bus.host_writedata),
    .rd_en   (pop_p0),
    .rd_data (fifo_rd_data),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_RUN;
      vld_p1         <= 1'b0;
      active_buffer  <= 1'b0;
      commit_pending <= 1'b0;
      frame_count    <= 8'd0;
      err_flags      <= 2'b00;
    end else begin
      vld_p1 <= pop_p0;

      if (push_p0 && fifo_full && !pop_p0) err_flags[0] <= 1'b1;
      if (illegal_p0)                      err_flags[1] <= 1'b1;

      // a commit arriving during the swap cycle targets the new back buffer
      if (state == ST_SWAP)
        commit_pending <= bus.host_commit;
      else if (bus.host_commit)
        commit_pending <= 1'b1;

      case (state)
        ST_RUN: begin
          if (commit_pending && fifo_empty && !vld_p1) state <= ST_WAIT_VBLANK;
        end
        ST_WAIT_VBLANK: begin
          if (vblank_hit) state <= ST_SWAP;
        end
        ST_SWAP: begin
          active_buffer <= ~active_buffer;
          frame_count   <= frame_count + 8'd1;
          state         <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // stage p1: popped word or swap word onto the broadcast bus, idle otherwise
  always_comb begin
    disp_word = IDLE_WORD;
    if (vld_p1) begin
      disp_word          = fifo_rd_data;
      disp_word[BUF_BIT] = ~active_buffer;
    end else if (state == ST_SWAP) begin
      disp_word = swap_word(~active_buffer);
    end
  end

  assign bus.disp_writedata = disp_word;
  assign bus.active_buffer  = active_buffer;
  assign bus.host_ready     = !fifo_full;
  assign bus.commit_pending = commit_pending;
  assign bus.fifo_count     = fifo_cnt;
  assign bus.frame_count    = frame_count;
  assign bus.err_flags      = err_flags;
endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// Directed bench for sprite_cmd_scheduler: drain, overflow, illegal words,
// vblank swap, reset in WAIT_VBLANK and frame counter wrap.
module tb_sprite_cmd_scheduler;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  sprite_cmd_scheduler_if #(.FIFO_DEPTH(16)) bus ();

  sprite_cmd_scheduler #(
    .FIFO_DEPTH  (16),
    .VBLANK_LINE (10'd480)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] upd_word(input int i);
    return {6'(i + 1), 5'd0, 4'h1, 3'd0, 1'b0, 13'(i)};
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_disp"},    bus.disp_writedata, 32'h0);
    chk({tag, "_active"},  32'(bus.active_buffer), 32'd0);
    chk({tag, "_pending"}, 32'(bus.commit_pending), 32'd0);
    chk({tag, "_count"},   32'(bus.fifo_count), 32'd0);
    chk({tag, "_frame"},   32'(bus.frame_count), 32'd0);
    chk({tag, "_err"},     32'(bus.err_flags), 32'd0);
    chk({tag, "_ready"},   32'(bus.host_ready), 32'd1);
  endtask

  task automatic commit_to_wait();
    bus.host_commit = 1'b1;
    step();
    bus.host_commit = 1'b0;
    step();
  endtask

  task automatic vblank_swap();
    bus.vcount = 10'd480;
    step();
    bus.vcount = 10'd0;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.host_write     = 1'b0;
    bus.host_writedata = 32'h0;
    bus.host_commit    = 1'b0;
    bus.hcount         = 10'd0;
    bus.vcount         = 10'd0;
    step();
    step();
    chk_reset_values("rst");
    reset = 1'b1;
    step();

    // three bit13=1 updates plus one bit13=0 update, drained back to back
    bus.host_write = 1'b1;
    bus.host_writedata = 32'h040220AB;
    step();
    chk("drain_cnt1", 32'(bus.fifo_count), 32'd1);
    bus.host_writedata = 32'h080220CD;
    step();
    chk("drain_w0", bus.disp_writedata, 32'h040220AB);
    bus.host_writedata = 32'h0C022001;
    step();
    chk("drain_w1", bus.disp_writedata, 32'h080220CD);
    bus.host_writedata = 32'h10020005;
    step();
    chk("drain_w2", bus.disp_writedata, 32'h0C022001);
    bus.host_write = 1'b0;
    step();
    chk("drain_w3_bit13", bus.disp_writedata, 32'h10022005);
    step();
    chk("drain_idle", bus.disp_writedata, 32'h0);
    chk("drain_empty", 32'(bus.fifo_count), 32'd0);

    // two words then commit, swap at line 480
    bus.host_write = 1'b1;
    bus.host_writedata = 32'h14020111;
    step();
    bus.host_writedata = 32'h18020222;
    step();
    chk("cm_wa", bus.disp_writedata, 32'h14022111);
    bus.host_write = 1'b0;
    bus.host_commit = 1'b1;
    step();
    bus.host_commit = 1'b0;
    chk("cm_wb", bus.disp_writedata, 32'h18022222);
    chk("cm_pending", 32'(bus.commit_pending), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("cm_wait_idle", bus.disp_writedata, 32'h0);
    end
    bus.vcount = 10'd480;
    step();
    bus.vcount = 10'd0;
    chk("cm_swap_word", bus.disp_writedata, 32'h001E2000);
    chk("cm_active_pre", 32'(bus.active_buffer), 32'd0);
    step();
    chk("cm_after_idle", bus.disp_writedata, 32'h0);
    chk("cm_active", 32'(bus.active_buffer), 32'd1);
    chk("cm_frame", 32'(bus.frame_count), 32'd1);
    chk("cm_pending_clr", 32'(bus.commit_pending), 32'd0);

    // fill in WAIT_VBLANK, overflow on the 17th word
    commit_to_wait();
    step();
    bus.host_write = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.host_writedata = upd_word(i);
      step();
    end
    chk("ovf_full_cnt", 32'(bus.fifo_count), 32'd16);
    chk("ovf_ready", 32'(bus.host_ready), 32'd0);
    chk("ovf_no_err_yet", 32'(bus.err_flags), 32'd0);
    bus.host_writedata = 32'h7C02_1FFF;
    step();
    bus.host_write = 1'b0;
    chk("ovf_cnt", 32'(bus.fifo_count), 32'd16);
    chk("ovf_err", 32'(bus.err_flags), 32'd1);
    chk("ovf_bus_idle", bus.disp_writedata, 32'h0);
    bus.vcount = 10'd480;
    step();
    bus.vcount = 10'd0;
    chk("ovf_swap_word", bus.disp_writedata, 32'h001E0000);
    step();
    chk("ovf_active", 32'(bus.active_buffer), 32'd0);
    chk("ovf_frame", 32'(bus.frame_count), 32'd2);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("ovf_drain", bus.disp_writedata, upd_word(i) | 32'h00002000);
    end
    step();
    chk("ovf_17th_dropped", bus.disp_writedata, 32'h0);

    // illegal swap word from the host
    bus.host_write = 1'b1;
    bus.host_writedata = 32'h041E0000;
    step();
    bus.host_write = 1'b0;
    chk("ill_cnt", 32'(bus.fifo_count), 32'd0);
    chk("ill_err", 32'(bus.err_flags), 32'd3);
    step();
    chk("ill_bus", bus.disp_writedata, 32'h0);

    // reset while waiting for vblank
    commit_to_wait();
    step();
    bus.host_write = 1'b1;
    bus.host_writedata = 32'h1C020333;
    step();
    bus.host_write = 1'b0;
    chk("rw_cnt", 32'(bus.fifo_count), 32'd1);
    chk("rw_pending", 32'(bus.commit_pending), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_values("rw_async");
    step();
    reset = 1'b1;
    bus.vcount = 10'd480;
    step();
    bus.vcount = 10'd0;
    chk("rw_no_swap", bus.disp_writedata, 32'h0);
    step();
    chk_reset_values("rw_after");

    // 256 swaps wrap the frame counter
    for (int i = 0; i < 255; i++) begin
      commit_to_wait();
      step();
      vblank_swap();
    end
    chk("wrap_frame255", 32'(bus.frame_count), 32'd255);
    chk("wrap_active255", 32'(bus.active_buffer), 32'd1);
    commit_to_wait();
    step();
    vblank_swap();
    chk("wrap_frame0", 32'(bus.frame_count), 32'd0);
    chk("wrap_active0", 32'(bus.active_buffer), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_cmd_scheduler.md
SPRITE_CMD_SCHEDULER -- requirements
Module: sprite_cmd_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: command FIFO entries, a power of two.
REQ-002 Parameter VBLANK_LINE, default 10'd480: vcount value at which a pending buffer swap is issued.
REQ-003 Port clk  in  1: single clock; all logic is in this domain.
REQ-004 Port reset  in  1: asynchronous, active-low reset (asserted when 0).
REQ-005 Port host_write  in  1: host pushes host_writedata this cycle.
REQ-006 Port host_writedata  in  32: command word with the display bus field layout.
REQ-007 Port host_commit  in  1: single-cycle request to present the back buffer at the next vblank.
REQ-008 Port hcount, vcount  in  10 each: raster position from the VGA timing block.
REQ-009 Port disp_writedata  out  32: broadcast command bus to all sprite display components.
REQ-010 Port active_buffer  out  1: currently displayed buffer index.
REQ-011 Port host_ready  out  1: FIFO not full.
REQ-012 Port commit_pending  out  1: commit accepted, swap not yet issued.
REQ-013 Port fifo_count  out  $clog2(FIFO_DEPTH)+1: current occupancy.
REQ-014 Port frame_count  out  8: number of swaps issued, modulo 256.
REQ-015 Port err_flags  out  2: sticky; bit0 overflow, bit1 illegal swap word from host.

Function
REQ-016 Word fields: [31:26] component id, [25:21] child, [20:17] control code, [16:14] data type, [13] buffer select, [12:0] data.
REQ-017 Idle/no-op word SHALL be 32'h0 (control code 0); disp_writedata is 32'h0 in every cycle that carries no command.
REQ-018 host_write with FIFO full: word dropped, err_flags[0] set; host_write with a simultaneous pop on a full FIFO is accepted.
REQ-019 Host word with control code 4'hF: dropped at the FIFO input, not counted, err_flags[1] set.
REQ-020 States: RUN, WAIT_VBLANK, SWAP; reset state RUN.
REQ-021 RUN: pop one word per cycle while FIFO non-empty; the popped word appears on disp_writedata on the next cycle (latency 1) with bit 13 forced to ~active_buffer; all other bits unchanged.
REQ-022 host_commit while commit_pending=0: commit_pending set next cycle; while commit_pending=1: ignored.
REQ-023 RUN -> WAIT_VBLANK when commit_pending=1 and FIFO empty with no pop in flight.
REQ-024 WAIT_VBLANK: no pops; writes still accepted; -> SWAP on the cycle where vcount==VBLANK_LINE and hcount==0; if that point has already passed, wait for the next frame.
REQ-025 SWAP (exactly one cycle): disp_writedata = control code 4'hF, bit13 = ~active_buffer, all other bits 0; active_buffer toggles, commit_pending clears, frame_count increments (255 wraps to 0) on the same edge; -> RUN.
REQ-026 host_commit in the SWAP cycle is treated as a new commit against the new back buffer.
REQ-027 err_flags clear only on reset.

Reset
REQ-028 Reset asserted: FIFO emptied, state RUN, disp_writedata 32'h0, active_buffer 0, commit_pending 0, frame_count 0, err_flags 0, fifo_count 0, host_ready 1; effective immediately, including mid-drain or in WAIT_VBLANK.

Structure
REQ-029 Package sprite_sched_pkg holds: field bit positions, control code constants CC_NOP=4'h0, CC_UPDATE=4'h1, CC_SWAP=4'hF, and the state enum.
REQ-030 FIFO SHALL be sub-module sched_cmd_fifo (synchronous, registered read, count output); FSM and bus mux in the top.

Verification
REQ-031 Push 3 CC_UPDATE words with bit13=1 while active_buffer=0 -> 3 consecutive bus words, bit13=1, first one cycle after pop start, then 32'h0.
REQ-032 Push 16 words with no dispatch possible (WAIT_VBLANK), push a 17th -> dropped, err_flags=2'b01, fifo_count=16.
REQ-033 Push 2 words, commit -> both drain, bus idle until vcount=480,hcount=0, one word 32'h001E2000 (control F, bit13=1), active_buffer=1, frame_count=1.
REQ-034 Host pushes a control-F word -> not dispatched, fifo_count unchanged, err_flags[1]=1.
REQ-035 Commit, then reset low in WAIT_VBLANK, release -> no swap at line 480, active_buffer=0, FIFO empty, all outputs at reset values.
REQ-036 256 commit/swap cycles -> frame_count wraps to 0, active_buffer returns to 0.
